// File: rtl/stream_gasket_if.sv
// Signal bundle between stream_gasket and its surroundings: the narrow USB stream,
// the wide FWFT FIFO ports, mode select and status.
interface stream_gasket_if #(
    parameter int NARROW_W = 16,
    parameter int RATIO    = 8
);
    localparam int WIDE_W = NARROW_W * RATIO;

    logic [1:0]          mode;
    logic [NARROW_W-1:0] usb_do;
    logic                usb_do_valid;
    logic                usb_do_ready;
    logic [WIDE_W-1:0]   fifo_di;
    logic                fifo_wren;
    logic                fifo_full;
    logic [WIDE_W-1:0]   fifo_do;
    logic                fifo_empty;
    logic                fifo_rden;
    logic [NARROW_W-1:0] usb_di;
    logic                usb_di_valid;
    logic                usb_di_ready;
    logic                wrerr_in;
    logic                rderr_in;
    logic [1:0]          err;
    logic [15:0]         partial_cnt;

    // gasket side
    modport slave (
        input  mode, usb_do, usb_do_valid, fifo_full, fifo_do, fifo_empty,
               usb_di_ready, wrerr_in, rderr_in,
        output usb_do_ready, fifo_di, fifo_wren, fifo_rden, usb_di, usb_di_valid,
               err, partial_cnt
    );

    // environment side (USB core, FIFO, control)
    modport master (
        output mode, usb_do, usb_do_valid, fifo_full, fifo_do, fifo_empty,
               usb_di_ready, wrerr_in, rderr_in,
        input  usb_do_ready, fifo_di, fifo_wren, fifo_rden, usb_di, usb_di_valid,
               err, partial_cnt
    );
endinterface

// File: rtl/stream_gasket.sv
// Narrow<->wide stream bridge between ezusb_io and a wide FWFT FIFO, ifclk domain.
// Packs USB words (or test pattern) into wide words, unpacks wide words to USB.
//
// Pack FSM
//   state | meaning
//   FILL  | collecting narrow words into slots 0..RATIO-1, idle flush armed when partial
//   WRITE | wide word complete, waiting for a not-full cycle to strobe fifo_wren
module stream_gasket #(
    parameter int                  NARROW_W      = 16,
    parameter int                  RATIO         = 8,
    parameter int                  FLUSH_TIMEOUT = 1024,
    parameter int                  TEST_DIV      = 4,
    parameter logic [NARROW_W-1:0] PAD           = '0
) (
    input logic            ifclk,
    input logic            reset,
    stream_gasket_if.slave bus
);
    localparam int WIDE_W    = NARROW_W * RATIO;
    localparam int SLOT_W    = $clog2(RATIO);
    localparam int REM_W     = $clog2(RATIO + 1);
    localparam int DIV_W     = $clog2(TEST_DIV);
    localparam int IDLE_W    = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam int IDLE_LOAD = (FLUSH_TIMEOUT > 1) ? FLUSH_TIMEOUT - 1 : 0;
    localparam bit FLUSH_EN  = (FLUSH_TIMEOUT != 0);

    typedef enum logic {
        FILL  = 1'b0,
        WRITE = 1'b1
    } pack_state_t;

    pack_state_t         state_q, state_d;
    logic [1:0]          mode_buf, pack_mode, cur_mode;
    logic [SLOT_W-1:0]   slot_q;
    logic [DIV_W-1:0]    div_q;
    logic [IDLE_W-1:0]   idle_q;
    logic [NARROW_W-1:0] gen_cnt;
    logic [WIDE_W-1:0]   data_q;
    logic [15:0]         partial_q;
    logic [1:0]          err_q;

    logic                accept, flush, last_slot, div_tick, usb_do_ready, fifo_wren;
    logic [NARROW_W-1:0] word_in;

    // A new mode only takes effect on a word boundary.
    assign cur_mode  = (state_q == FILL && slot_q == '0) ? mode_buf : pack_mode;
    assign div_tick  = (div_q == '0);
    assign last_slot = (slot_q == SLOT_W'(RATIO - 1));
    assign word_in   = (cur_mode == 2'd0) ? bus.usb_do : gen_cnt;

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) state_q <= FILL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        usb_do_ready = 1'b0;
        fifo_wren    = 1'b0;
        accept       = 1'b0;
        flush        = 1'b0;
        case (state_q)
            FILL: begin
                usb_do_ready = (cur_mode == 2'd0);
                case (cur_mode)
                    2'd0:    accept = bus.usb_do_valid;
                    2'd1:    accept = 1'b1;
                    2'd2:    accept = div_tick;
                    default: accept = 1'b0;
                endcase
                flush = FLUSH_EN && !accept && slot_q != '0 && idle_q == '0;
                if ((accept && last_slot) || flush) state_d = WRITE;
            end
            WRITE: begin
                fifo_wren = !bus.fifo_full;
                if (!bus.fifo_full) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            mode_buf  <= 2'd3;
            pack_mode <= 2'd3;
            div_q     <= DIV_W'(TEST_DIV - 1);
            slot_q    <= '0;
            idle_q    <= '0;
            gen_cnt   <= '0;
            data_q    <= '0;
            partial_q <= '0;
        end else begin
            mode_buf  <= bus.mode;
            pack_mode <= cur_mode;

            // Divider free-runs in mode 2 so the WRITE cycle does not stretch the word period.
            if (cur_mode == 2'd2) div_q <= div_tick ? DIV_W'(TEST_DIV - 1) : div_q - 1'b1;
            else                  div_q <= DIV_W'(TEST_DIV - 1);

            if (accept) begin
                data_q[int'(slot_q)*NARROW_W +: NARROW_W] <= word_in;
                slot_q <= last_slot ? '0 : slot_q + 1'b1;
                idle_q <= IDLE_W'(IDLE_LOAD);
                if (cur_mode != 2'd0) gen_cnt <= gen_cnt + 1'b1;
            end else if (flush) begin
                for (int i = 0; i < RATIO; i++) begin
                    if (i >= int'(slot_q)) data_q[i*NARROW_W +: NARROW_W] <= PAD;
                end
                slot_q    <= '0;
                partial_q <= partial_q + 1'b1;
            end else if (state_q == FILL && slot_q != '0 && idle_q != '0) begin
                idle_q <= idle_q - 1'b1;
            end
        end
    end

    logic [WIDE_W-1:0] shift_q;
    logic [REM_W-1:0]  rem_q;
    logic              di_valid, consume, load;

    assign di_valid = (rem_q != '0);
    assign consume  = di_valid && bus.usb_di_ready;
    // Reloading on the last consumed slot keeps the narrow stream gap-free.
    assign load     = (rem_q == '0 || (rem_q == REM_W'(1) && consume)) && !bus.fifo_empty;

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            rem_q   <= '0;
        end else if (load) begin
            shift_q <= bus.fifo_do;
            rem_q   <= REM_W'(RATIO);
        end else if (consume) begin
            shift_q <= shift_q >> NARROW_W;
            rem_q   <= rem_q - 1'b1;
        end
    end

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) err_q <= '0;
        else       err_q <= err_q | {bus.rderr_in, bus.wrerr_in};
    end

    assign bus.usb_do_ready = usb_do_ready;
    assign bus.fifo_wren    = fifo_wren;
    assign bus.fifo_di      = data_q;
    // rem is already 0 under reset; the gate stops a FWFT read while reset is held.
    assign bus.fifo_rden    = load && !reset;
    assign bus.usb_di       = shift_q[NARROW_W-1:0];
    assign bus.usb_di_valid = di_valid;
    assign bus.err          = err_q;
    assign bus.partial_cnt  = partial_q;
endmodule

// File: tb/tb_stream_gasket.sv
// Directed + randomized bench for stream_gasket; the bench plays USB source/sink and both FIFO sides.
module tb_stream_gasket;
    localparam int NW    = 16;
    localparam int RATIO = 8;
    localparam int WW    = NW * RATIO;
    localparam int FT    = 8;
    localparam int TD    = 4;
    localparam logic [NW-1:0] PAD = 16'hBEEF;

    logic ifclk = 1'b0;
    logic reset = 1'b0;

    stream_gasket_if #(.NARROW_W(NW), .RATIO(RATIO)) bus ();

    stream_gasket #(
        .NARROW_W(NW), .RATIO(RATIO), .FLUSH_TIMEOUT(FT), .TEST_DIV(TD), .PAD(PAD)
    ) dut (
        .ifclk(ifclk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 ifclk = ~ifclk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    bit rden_seen;

    logic [WW-1:0] fifo_q[$];
    logic [WW-1:0] wr_log[$];
    int            wr_cyc[$];

    // reference model state for the randomized phase
    logic [NW-1:0] m_q[$];
    logic [NW-1:0] exp_n[$];
    logic [WW-1:0] m_word;
    bit            m_block;
    int            m_idle, m_partial, gap;
    logic [NW-1:0] pend_d;
    bit            prev_hold;
    logic [NW-1:0] prev_di;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] pack_words(input logic [NW-1:0] q[$]);
        logic [WW-1:0] r;
        for (int i = 0; i < RATIO; i++) r[i*NW +: NW] = (i < q.size()) ? q[i] : PAD;
        return r;
    endfunction

    function automatic logic [WW-1:0] rnd_wide();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic fifo_drive();
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_do    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic fifo_load(input logic [WW-1:0] w);
        fifo_q.push_back(w);
        for (int i = 0; i < RATIO; i++) exp_n.push_back(w[i*NW +: NW]);
        fifo_drive();
    endtask

    task automatic settle();
        @(negedge ifclk);
        rden_seen = bus.fifo_rden;
        if (bus.fifo_full)  chk("wren_while_full", bus.fifo_wren, 0);
        if (bus.fifo_empty) chk("rden_while_empty", bus.fifo_rden, 0);
        if (bus.fifo_wren) begin
            wr_log.push_back(bus.fifo_di);
            wr_cyc.push_back(cyc);
        end
        if (bus.fifo_rden) rd_cnt++;
    endtask

    task automatic adv();
        @(posedge ifclk);
        #1;
        if (rden_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_drive();
        cyc++;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic push(input logic [NW-1:0] d, input string tag);
        bus.usb_do       = d;
        bus.usb_do_valid = 1'b1;
        settle();
        chk(tag, bus.usb_do_ready, 1);
        adv();
        bus.usb_do_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_usb_do_ready"}, bus.usb_do_ready, 0);
        chk({p, "_fifo_wren"},    bus.fifo_wren, 0);
        chk({p, "_fifo_di"},      bus.fifo_di, 0);
        chk({p, "_fifo_rden"},    bus.fifo_rden, 0);
        chk({p, "_usb_di_valid"}, bus.usb_di_valid, 0);
        chk({p, "_usb_di"},       bus.usb_di, 0);
        chk({p, "_err"},          bus.err, 0);
        chk({p, "_partial_cnt"},  bus.partial_cnt, 0);
    endtask

    // One cycle of the randomized phase: pack and unpack checked against the models.
    task automatic rnd_cycle(input bit drive);
        bit valid;
        valid = drive && (gap == 0);
        if (drive && gap > 0) gap--;
        bus.usb_do       = pend_d;
        bus.usb_do_valid = valid;
        bus.usb_di_ready = drive ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (drive && fifo_q.size() < 3 && $urandom_range(0, 5) == 0) fifo_load(rnd_wide());
        settle();
        chk("r_ready", bus.usb_do_ready, !m_block);
        chk("r_wren", bus.fifo_wren, m_block);
        if (m_block) chk("r_data", bus.fifo_di, m_word);
        if (prev_hold) begin
            chk("r_hold_valid", bus.usb_di_valid, 1);
            chk("r_hold_data", bus.usb_di, prev_di);
        end
        if (bus.usb_di_valid && bus.usb_di_ready) begin
            if (exp_n.size() == 0) chk("r_di_extra", bus.usb_di_valid, 0);
            else                   chk("r_di", bus.usb_di, exp_n.pop_front());
        end
        prev_hold = bus.usb_di_valid && !bus.usb_di_ready;
        prev_di   = bus.usb_di;
        if (m_block) begin
            m_block = 1'b0;
        end else if (valid) begin
            m_q.push_back(pend_d);
            m_idle = 0;
            pend_d = NW'($urandom());
            gap    = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 3);
            if (m_q.size() == RATIO) begin
                m_word = pack_words(m_q);
                m_q.delete();
                m_block = 1'b1;
            end
        end else if (m_q.size() != 0) begin
            m_idle++;
            if (m_idle == FT) begin
                m_word = pack_words(m_q);
                m_q.delete();
                m_partial++;
                m_block = 1'b1;
                m_idle  = 0;
            end
        end
        adv();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] w1, w2, w3, wa, wb, w6;
        logic [NW-1:0] q[$];
        int            n0, base, budget, rd0;

        bus.mode = 2'd0; bus.usb_do = '0; bus.usb_do_valid = 1'b0; bus.fifo_full = 1'b0;
        bus.usb_di_ready = 1'b0; bus.wrerr_in = 1'b0; bus.rderr_in = 1'b0;
        fifo_drive();

        #1 reset = 1'b1;
        #2 check_reset_vals("rst");
        repeat (2) @(posedge ifclk);
        #1 reset = 1'b0;

        // T1: eight back-to-back USB words -> one wide word, first word in the LSBs
        step(); step();
        w1 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        for (int i = 0; i < RATIO; i++) push(NW'(i + 1), "t1_ready");
        settle();
        chk("t1_write_ready", bus.usb_do_ready, 0);
        chk("t1_wren", bus.fifo_wren, 1);
        chk("t1_data", bus.fifo_di, w1);
        adv();
        settle();
        chk("t1_ready_back", bus.usb_do_ready, 1);
        chk("t1_wren_once", bus.fifo_wren, 0);
        adv();

        // T2: fifo_full held for 5 cycles at the end of packing
        n0 = wr_log.size();
        for (int i = 0; i < RATIO; i++) w2[i*NW +: NW] = NW'(16'h0100 + i);
        for (int i = 0; i < RATIO - 1; i++) push(NW'(16'h0100 + i), "t2_ready");
        bus.fifo_full = 1'b1;
        push(NW'(16'h0107), "t2_ready_last");
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t2_wren_held", bus.fifo_wren, 0);
            chk("t2_ready_low", bus.usb_do_ready, 0);
            chk("t2_data_stable", bus.fifo_di, w2);
            adv();
        end
        bus.fifo_full = 1'b0;
        settle();
        chk("t2_wren", bus.fifo_wren, 1);
        chk("t2_data", bus.fifo_di, w2);
        adv();
        settle();
        chk("t2_wren_once", bus.fifo_wren, 0);
        chk("t2_ready_back", bus.usb_do_ready, 1);
        adv();
        chk("t2_single_write", wr_log.size() - n0, 1);

        // T3: three words then idle -> padded flush after FT idle cycles
        q = '{16'h00A1, 16'h00A2, 16'h00A3};
        w3 = pack_words(q);
        foreach (q[i]) push(q[i], "t3_ready");
        for (int k = 1; k <= FT; k++) begin
            settle();
            chk("t3_no_early_wren", bus.fifo_wren, 0);
            chk("t3_ready_idle", bus.usb_do_ready, 1);
            adv();
        end
        settle();
        chk("t3_flush_wren", bus.fifo_wren, 1);
        chk("t3_flush_data", bus.fifo_di, w3);
        chk("t3_partial_cnt", bus.partial_cnt, 1);
        adv();
        n0 = wr_log.size();
        repeat (20) step();
        chk("t3_no_flush_when_empty", wr_log.size() - n0, 0);

        // T4: two preloaded wide words -> 16 gap-free narrow words, two reads
        bus.usb_di_ready = 1'b1;
        rd0 = rd_cnt;
        fifo_load(rnd_wide());
        fifo_load(rnd_wide());
        settle();
        chk("t4_latency_valid", bus.usb_di_valid, 0);
        chk("t4_load_rden", bus.fifo_rden, 1);
        adv();
        for (int i = 0; i < 2 * RATIO; i++) begin
            settle();
            chk("t4_valid", bus.usb_di_valid, 1);
            chk("t4_data", bus.usb_di, exp_n.pop_front());
            adv();
        end
        settle();
        chk("t4_valid_end", bus.usb_di_valid, 0);
        adv();
        chk("t4_rden_count", rd_cnt - rd0, 2);

        // T5: divided test pattern, then full rate after a mid-word mode change
        base = wr_log.size();
        bus.mode = 2'd2;
        budget = 0;
        while (wr_log.size() < base + 2 && budget < 200) begin
            step();
            budget++;
        end
        chk("t5_timeout_a", budget < 200, 1);
        repeat (10) step();
        bus.mode = 2'd1;
        budget = 0;
        while (wr_log.size() < base + 4 && budget < 200) begin
            settle();
            if (wr_log.size() >= base + 4) bus.mode = 2'd3;
            adv();
            budget++;
        end
        chk("t5_timeout_b", budget < 200, 1);
        for (int j = 0; j < 4; j++) begin
            q.delete();
            for (int i = 0; i < RATIO; i++) q.push_back(NW'(RATIO * j + i));
            chk($sformatf("t5_word%0d", j), wr_log[base + j], pack_words(q));
        end
        chk("t5_period_div_a", wr_cyc[base + 1] - wr_cyc[base], 32);
        chk("t5_period_div_b", wr_cyc[base + 2] - wr_cyc[base + 1], 32);
        chk("t5_period_full", wr_cyc[base + 3] - wr_cyc[base + 2], 9);
        n0 = wr_log.size();
        repeat (20) step();
        chk("t5_mode3_idle", wr_log.size() - n0, 0);

        // T6: sticky errors, then reset in the middle of a pack and with a loaded unpack buffer
        bus.wrerr_in = 1'b1; step(); bus.wrerr_in = 1'b0;
        settle(); chk("t6_err_wr", bus.err, 2'b01); adv();
        repeat (3) step();
        settle(); chk("t6_err_wr_sticky", bus.err, 2'b01); adv();
        bus.rderr_in = 1'b1; step(); bus.rderr_in = 1'b0;
        settle(); chk("t6_err_both", bus.err, 2'b11); adv();
        repeat (3) step();
        settle(); chk("t6_err_both_sticky", bus.err, 2'b11); adv();

        bus.mode = 2'd0;
        step(); step();
        bus.usb_di_ready = 1'b0;
        wa = rnd_wide();
        wb = rnd_wide();
        fifo_q.push_back(wa);
        fifo_q.push_back(wb);
        fifo_drive();
        for (int i = 0; i < 4; i++) push(NW'(16'h0300 + i), "t6_ready_pre");
        settle();
        #2 reset = 1'b1;
        #1 check_reset_vals("t6_async");
        repeat (3) begin
            adv();
            settle();
            chk("t6_rst_wren", bus.fifo_wren, 0);
            chk("t6_rst_rden", bus.fifo_rden, 0);
        end
        adv();
        reset = 1'b0;
        settle();
        chk("t6_post_ready", bus.usb_do_ready, 0);
        adv();
        q.delete();
        for (int i = 0; i < RATIO; i++) q.push_back(NW'(16'h0400 + i));
        w6 = pack_words(q);
        foreach (q[i]) push(q[i], "t6_ready_post");
        settle();
        chk("t6_post_wren", bus.fifo_wren, 1);
        chk("t6_post_data", bus.fifo_di, w6);
        adv();
        bus.usb_di_ready = 1'b1;
        settle();
        chk("t6_post_valid", bus.usb_di_valid, 1);
        chk("t6_post_di", bus.usb_di, wb[NW-1:0]);
        adv();
        repeat (RATIO - 1) step();
        settle();
        chk("t6_post_drained", bus.usb_di_valid, 0);
        adv();

        // Randomized phase against the models
        exp_n.delete();
        m_q.delete();
        m_block = 1'b0; m_idle = 0; m_partial = 0; gap = 0; prev_hold = 1'b0;
        pend_d = NW'($urandom());
        for (int n = 0; n < 1500; n++) rnd_cycle(1'b1);
        budget = 0;
        while ((exp_n.size() != 0 || m_q.size() != 0 || m_block) && budget < 60) begin
            rnd_cycle(1'b0);
            budget++;
        end
        chk("r_drain_timeout", budget < 60, 1);
        settle();
        chk("r_final_valid", bus.usb_di_valid, 0);
        chk("r_partial_cnt", bus.partial_cnt, m_partial);
        adv();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/stream_gasket.md
Name: stream_gasket

Overview:
Parametrised bridge between the narrow EZ-USB streaming interface and a wide FWFT FIFO, such as the DRAM FIFO.
- Packs narrow USB words into wide FIFO words and unpacks wide FIFO words back into narrow USB words.
- Generalises the fixed 16/128 glue: configurable width ratio, idle-timeout flush of partial words, configurable-rate test pattern generator, sticky error capture.
- Runs in the ifclk domain between ezusb_io and the FIFO.

Parameters:
NARROW_W, 16, USB-side word width in bits.
RATIO, 8, narrow words per wide word (power of two, 2..16); WIDE_W = NARROW_W*RATIO.
FLUSH_TIMEOUT, 1024, idle ifclk cycles before a partial pack word is padded and written; 0 disables flush.
TEST_DIV, 4, mode-2 generator rate: one word every TEST_DIV cycles (>=2).
PAD, 0, NARROW_W-bit fill value for padded slots.

Ports:
ifclk  in  1  clock, all logic rising edge
reset  in  1  asynchronous active-high reset
mode  in  2  0=USB input, 1=test full rate, 2=test divided, 3=pack path idle
usb_do  in  NARROW_W  narrow data from USB
usb_do_valid  in  1  usb_do valid
usb_do_ready  out  1  gasket accepts usb_do this cycle
fifo_di  out  WIDE_W  packed word
fifo_wren  out  1  write strobe
fifo_full  in  1  FIFO full
fifo_do  in  WIDE_W  FWFT head word
fifo_empty  in  1  FIFO empty
fifo_rden  out  1  consume head word
usb_di  out  NARROW_W  narrow data to USB
usb_di_valid  out  1  usb_di valid
usb_di_ready  in  1  USB accepts usb_di
wrerr_in  in  1  FIFO write error
rderr_in  in  1  FIFO read error
err  out  2  sticky {rderr, wrerr}
partial_cnt  out  16  count of padded (flushed) words written, wraps

Behaviour:
- Reset values: usb_do_ready=0, fifo_wren=0, fifo_di=0, fifo_rden=0, usb_di_valid=0, usb_di=0, err=0, partial_cnt=0.
- Reset state: pack FSM in FILL with slot count 0; unpack remaining count 0; mode_buf=3.
- mode is registered into mode_buf every cycle. The pack path adopts a new mode_buf only when in FILL with slot count 0; mid-word mode changes wait for the word to complete.

Pack FSM states: FILL, WRITE.
- FILL:
  - usb_do_ready = (mode_buf==0).
  - A narrow word is accepted when (mode0: usb_do_valid && usb_do_ready), (mode1: every cycle), (mode2: every TEST_DIV-th cycle, via divider counter).
  - Accepted word i (0..RATIO-1) goes to fifo_di bits [i*NARROW_W +: NARROW_W], so the first word lands in the LSBs.
  - On accepting slot RATIO-1 -> WRITE.
- Test data: a NARROW_W-bit counter, reset 0, increments per generated word and wraps at 2^NARROW_W.
- Flush:
  - An idle counter clears on every accepted word and counts while in FILL with slot count>0 and nothing accepted.
  - When it reaches FLUSH_TIMEOUT (nonzero): remaining slots are filled with PAD, partial_cnt increments, -> WRITE.
  - With slot count 0 the idle counter stays 0.
- WRITE:
  - usb_do_ready=0.
  - fifo_wren=1 for exactly one cycle, in the first cycle with fifo_full=0; then -> FILL with slot count 0.
  - fifo_wren is never asserted while fifo_full=1.
  - fifo_di is held stable throughout WRITE.
- mode 3: no words accepted. A partial word already in progress still flushes by timeout.

Unpack:
- Shift register buf plus remaining count rem (0..RATIO).
- usb_di = buf[NARROW_W-1:0]; usb_di_valid = (rem!=0).
- On usb_di_valid && usb_di_ready: buf shifts right by NARROW_W and rem decrements.
- Load condition: (rem==0, or rem==1 with that word being consumed this cycle) and fifo_empty=0.
  - On load: buf<=fifo_do, rem<=RATIO, fifo_rden=1 in that same cycle (combinational, FWFT).
  - The load gives gap-free output across wide-word boundaries.
- fifo_rden is never asserted while fifo_empty=1.
- Latency: first usb_di_valid occurs 1 cycle after fifo_empty falls with rem==0.
- usb_di and usb_di_valid are held while usb_di_ready=0.

Errors: err[0] |= wrerr_in, err[1] |= rderr_in; cleared only by reset.

Reset mid-operation: partial pack data and unpack buffer are discarded; no fifo_wren or fifo_rden is issued after reset asserts.

Test Plan:
1. mode0, RATIO=8: push usb_do 0x0001..0x0008 back-to-back -> one fifo_wren with fifo_di = 0x0008_0007_..._0001 (0x0001 in LSBs); usb_do_ready low for exactly the WRITE cycle(s).
2. Same with fifo_full=1 held 5 cycles at packing end -> fifo_wren held off, then a single pulse on the first not-full cycle; usb_do_ready stays 0 meanwhile; fifo_di unchanged.
3. FLUSH_TIMEOUT=8: push 3 words then idle -> after 8 idle cycles fifo_wren with slots 3..7 = PAD; partial_cnt=1.
4. Preload FIFO with 2 wide words, usb_di_ready=1 -> 16 consecutive valid narrow words in LSB-first order with no gap; fifo_rden exactly 2 pulses; then usb_di_valid=0.
5. mode2, TEST_DIV=4 -> fifo_wren every 32 cycles carrying counter values 0..7, then 8..15; switch to mode1 mid-word -> current word completes at rate /4, next word at 1 word/cycle.
6. Pulse wrerr_in, then rderr_in -> err=2'b01, then 2'b11, sticky; assert reset mid-pack -> all outputs return to reset values asynchronously, no stray fifo_wren.
